axis_div_unit: RTL

// - Iterative radix-2 integer divider acting as the responder on the divider AXI-stream port
//   of mycpu_top: two slave operand channels (divisor, dividend) and one master result channel.
// - Drop-in for the div/divu instances in soc_lite_top on the DPIC build, where vendor IP is absent.
// - One instance per opcode class: SIGNED=1 serves div, SIGNED=0 serves divu.

---
 rtl/axis_div_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axis_div_unit.sv
`default_nettype none
// =============================================================================
// Module   : axis_div_unit
// Purpose  : Iterative radix-2 restoring divider with AXI-stream operand/result
//            channels. Optional macro DIV_EARLY_OUT_EN short-circuits b==0 and
//            |a|<|b| operations.
// Revision : 1.0 - initial release
// =============================================================================
module axis_div_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               a_full_q, b_full_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q_q, sign_r_q, bzero_q;
  logic               early_q;
  logic               tvalid_q;
  logic [2*WIDTH-1:0] tdata_q;

  logic               w_dvd_hs, w_dvs_hs;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_step, w_quo_step;
  logic [WIDTH-1:0]   w_quo_fin, w_rem_fin, w_quo_out, w_rem_out;
  logic               w_early;

  assign s_axis_dividend_tready = (state_q == S_IDLE) && !a_full_q;
  assign s_axis_divisor_tready  = (state_q == S_IDLE) && !b_full_q;
  assign w_dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign w_dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;

  // The most negative value maps to its own bit pattern, read as an unsigned magnitude.
  assign w_sa    = SIGNED && a_q[WIDTH-1];
  assign w_sb    = SIGNED && b_q[WIDTH-1];
  assign w_abs_a = w_sa ? -a_q : a_q;
  assign w_abs_b = w_sb ? -b_q : b_q;

  assign w_shift    = {rem_q, quo_q[WIDTH-1]};
  assign w_ge       = w_shift >= {1'b0, dvs_q};
  assign w_rem_step = w_ge ? WIDTH'(w_shift - {1'b0, dvs_q}) : w_shift[WIDTH-1:0];
  assign w_quo_step = {quo_q[WIDTH-2:0], w_ge};

  assign w_quo_fin = early_q ? quo_q : w_quo_step;
  assign w_rem_fin = early_q ? rem_q : w_rem_step;
  assign w_quo_out = (sign_q_q && !bzero_q) ? -w_quo_fin : w_quo_fin;
  assign w_rem_out = sign_r_q ? -w_rem_fin : w_rem_fin;

`ifdef DIV_EARLY_OUT_EN
  // Early ops form their result in PREP and spend one idle CALC cycle before DONE.
  assign w_early = (b_q == '0) || (w_abs_a < w_abs_b);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      early_q <= 1'b0;
    end else if (state_q == S_PREP) begin
      early_q <= w_early;
    end
  end
`else
  assign w_early = 1'b0;
  assign early_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (a_full_q && b_full_q) state_d = S_PREP;
      S_PREP:  state_d = S_CALC;
      S_CALC:  if (early_q || (cnt_q == CNT_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      bzero_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= 1'b0;
      if (w_dvd_hs) begin
        a_q      <= s_axis_dividend_tdata;
        a_full_q <= 1'b1;
      end
      if (w_dvs_hs) begin
        b_q      <= s_axis_divisor_tdata;
        b_full_q <= 1'b1;
      end
      case (state_q)
        S_PREP: begin
          a_full_q <= 1'b0;
          b_full_q <= 1'b0;
          dvs_q    <= w_abs_b;
          sign_q_q <= w_sa ^ w_sb;
          sign_r_q <= w_sa;
          bzero_q  <= (b_q == '0);
          cnt_q    <= '0;
          if (w_early) begin
            quo_q <= (b_q == '0) ? '1 : '0;
            rem_q <= w_abs_a;
          end else begin
            quo_q <= w_abs_a;
            rem_q <= '0;
          end
        end
        S_CALC: begin
          if (!early_q) begin
            quo_q <= w_quo_step;
            rem_q <= w_rem_step;
          end
          cnt_q <= cnt_q + CNT_W'(1);
          // Result is registered on entry to DONE so the pulse coincides with the DONE cycle.
          if (state_d == S_DONE) begin
            tvalid_q <= 1'b1;
            tdata_q  <= {w_quo_out, w_rem_out};
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;

endmodule
`default_nettype wire
